fusion_pe_acc: RTL

- Parametrised successor to the fixed 16-bitbrick fusion PE.
- N_BB 2b×2b bitbricks are fused at run time into 2-bit, 4-bit or 8-bit multipliers, selected per beat. The products pass through a shift-add tree and are summed into a registered accumulator.
- Valid/ready handshakes on input and output; a result is emitted on the beat flagged last.
- Sits between the operand feeders and the array-level accumulation/writeback.

---
 rtl/fusion_pe_acc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fusion_pe_acc.sv
// Run-time fused 2b/4b/8b bitbrick multiplier with a pipelined shift-add tree and group accumulator.
// Optional saturating accumulation with a sticky out_ovf flag: define FUSION_PE_SAT_EN.
module fusion_pe_acc #(
  parameter int N_BB  = 16,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        mode,
  input  logic              sign_x,
  input  logic              sign_y,
  input  logic [2*N_BB-1:0] x,
  input  logic [2*N_BB-1:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);
  localparam int SUM_W = 16 + $clog2(N_BB) + 1;

  logic                    w_stall;
  logic                    r_s0_valid, r_s0_last, r_s0_sx, r_s0_sy;
  logic [1:0]              r_s0_mode;
  logic [2*N_BB-1:0]       r_s0_x, r_s0_y;
  logic                    r_s1_valid, r_s1_last;
  logic [1:0]              r_s1_mode;
  logic signed [5:0]       r_s1_prod [N_BB];
  logic signed [5:0]       w_prod [N_BB];
  logic signed [SUM_W-1:0] w_term [N_BB];
  logic signed [SUM_W-1:0] w_tree_sum;
  logic                    r_s2_valid, r_s2_last;
  logic signed [SUM_W-1:0] r_s2_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0]        r_out_data;
  logic                    r_out_valid;

  assign w_stall   = r_out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Each brick picks its 2-bit chunks from the fusion position; only MSB chunks honour the sign flags.
  for (genvar gi = 0; gi < N_BB; gi++) begin : g_brick
    localparam int XC4 = (gi % 4) % 2;
    localparam int YC4 = (gi % 4) / 2;
    localparam int XC8 = (gi % 16) % 4;
    localparam int YC8 = (gi % 16) / 4;
    localparam int B4  = 4 * (gi / 4);
    localparam int B8  = 8 * (gi / 16);
    localparam int SH4 = 2 * (XC4 + YC4);
    localparam int SH8 = 2 * (XC8 + YC8);

    logic [1:0]              w_xa, w_ya;
    logic                    w_xs, w_ys;
    logic signed [5:0]       w_mul;
    logic signed [SUM_W-1:0] w_ext;

    always_comb begin
      w_xa = r_s0_x[2*gi +: 2];
      w_ya = r_s0_y[2*gi +: 2];
      w_xs = r_s0_sx;
      w_ys = r_s0_sy;
      case (r_s0_mode)
        2'd1: begin
          w_xa = r_s0_x[B4 + 2*XC4 +: 2];
          w_ya = r_s0_y[B4 + 2*YC4 +: 2];
          w_xs = r_s0_sx && (XC4 == 1);
          w_ys = r_s0_sy && (YC4 == 1);
        end
        2'd2: begin
          w_xa = r_s0_x[B8 + 2*XC8 +: 2];
          w_ya = r_s0_y[B8 + 2*YC8 +: 2];
          w_xs = r_s0_sx && (XC8 == 3);
          w_ys = r_s0_sy && (YC8 == 3);
        end
        default: ;
      endcase
    end

    assign w_mul       = $signed({w_xs & w_xa[1], w_xa}) * $signed({w_ys & w_ya[1], w_ya});
    assign w_prod[gi]  = (r_s0_mode == 2'd3) ? 6'sd0 : w_mul;
    assign w_ext       = SUM_W'(r_s1_prod[gi]);
    assign w_term[gi]  = (r_s1_mode == 2'd1) ? (w_ext <<< SH4) :
                         (r_s1_mode == 2'd2) ? (w_ext <<< SH8) : w_ext;
  end

  always_comb begin
    w_tree_sum = '0;
    for (int i = 0; i < N_BB; i++) begin
      w_tree_sum = w_tree_sum + w_term[i];
    end
  end

`ifdef FUSION_PE_SAT_EN
  localparam int ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic signed [ADD_W-1:0] MAX_V = {{(ADD_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [ADD_W-1:0] MIN_V = {{(ADD_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [ADD_W-1:0] w_add_full;
  logic                    w_clamp_hi, w_clamp_lo, w_clamp;
  logic                    r_grp_ovf, r_out_ovf;

  assign w_add_full = ADD_W'(r_acc) + ADD_W'(r_s2_sum);
  assign w_clamp_hi = w_add_full > MAX_V;
  assign w_clamp_lo = w_add_full < MIN_V;
  assign w_clamp    = w_clamp_hi || w_clamp_lo;
  assign w_acc_next = w_clamp_hi ? MAX_V[ACC_W-1:0] :
                      w_clamp_lo ? MIN_V[ACC_W-1:0] : w_add_full[ACC_W-1:0];
  assign out_ovf    = r_out_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grp_ovf <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (!w_stall && r_s2_valid) begin
      if (r_s2_last) begin
        r_out_ovf <= r_grp_ovf || w_clamp;
        r_grp_ovf <= 1'b0;
      end else begin
        r_grp_ovf <= r_grp_ovf || w_clamp;
      end
    end
  end
`else
  assign w_acc_next = r_acc + ACC_W'(r_s2_sum);
  assign out_ovf    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0_valid  <= 1'b0;
      r_s0_last   <= 1'b0;
      r_s0_sx     <= 1'b0;
      r_s0_sy     <= 1'b0;
      r_s0_mode   <= '0;
      r_s0_x      <= '0;
      r_s0_y      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= '0;
      for (int i = 0; i < N_BB; i++) r_s1_prod[i] <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_sum    <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s0_valid <= in_valid;
      r_s0_last  <= in_last;
      r_s0_sx    <= sign_x;
      r_s0_sy    <= sign_y;
      r_s0_mode  <= mode;
      r_s0_x     <= x;
      r_s0_y     <= y;
      r_s1_valid <= r_s0_valid;
      r_s1_last  <= r_s0_last;
      r_s1_mode  <= r_s0_mode;
      for (int i = 0; i < N_BB; i++) r_s1_prod[i] <= w_prod[i];
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_sum   <= w_tree_sum;
      // Not stalled means any pending result is being consumed this edge.
      r_out_valid <= 1'b0;
      if (r_s2_valid) begin
        if (r_s2_last) begin
          r_out_data  <= w_acc_next;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end
endmodule
